// File: rtl/seg_scan_60.sv
// Two-digit multiplexed seven-segment driver for a modulo-60 counter.
// Captures the count, scans ones/tens digits, stretches carry onto dp, supports blink.
module seg_scan_60 #(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned BLINK_SLOTS   = 250,
  parameter int unsigned DP_HOLD_SLOTS = 100,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] value,
  input  logic       co,
  input  logic       blink,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned BW = $clog2(BLINK_SLOTS + 1);
  localparam int unsigned DW = $clog2(DP_HOLD_SLOTS + 1);

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);
  localparam logic [DW-1:0] DP_LOAD    = DW'(DP_HOLD_SLOTS);
  localparam logic [6:0]    SEG_INV    = {7{ACTIVE_LOW}};
  localparam logic [1:0]    AN_INV     = {2{ACTIVE_LOW}};

  typedef enum logic {SEL_ONES = 1'b0, SEL_TENS = 1'b1} sel_e;

  logic [6:0]    r_disp;
  logic [SW-1:0] r_scan_cnt;
  sel_e          r_sel;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_ph;
  logic [DW-1:0] r_dp_cnt;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [1:0]    r_an;

  logic          w_strobe;
  logic          w_blank;
  logic [6:0]    w_tens;
  logic [6:0]    w_ones;
  logic [6:0]    w_digit;
  logic [6:0]    w_seg;
  logic          w_dp;
  logic [1:0]    w_an;

  function automatic logic [6:0] seg7(input logic [6:0] d);
    case (d)
      7'd0:    seg7 = 7'h3F;
      7'd1:    seg7 = 7'h06;
      7'd2:    seg7 = 7'h5B;
      7'd3:    seg7 = 7'h4F;
      7'd4:    seg7 = 7'h66;
      7'd5:    seg7 = 7'h6D;
      7'd6:    seg7 = 7'h7D;
      7'd7:    seg7 = 7'h07;
      7'd8:    seg7 = 7'h7F;
      7'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;
    endcase
  endfunction

  assign w_strobe = (r_scan_cnt == SCAN_LAST);

  always_comb begin
    w_tens  = r_disp / 7'd10;
    w_ones  = r_disp % 7'd10;
    w_blank = blink & r_blink_ph;
    w_digit = (r_sel == SEL_TENS) ? w_tens : w_ones;
    w_an    = (r_sel == SEL_TENS) ? 2'b10 : 2'b01;
    w_seg   = '0;
    if (!w_blank) begin
      w_seg = (r_disp > 7'd59) ? 7'h40 : seg7(w_digit);
    end
    w_dp = (r_dp_cnt != '0) && (r_sel == SEL_ONES) && !w_blank;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp      <= '0;
      r_scan_cnt  <= '0;
      r_sel       <= SEL_ONES;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
      r_dp_cnt    <= '0;
      r_seg       <= SEG_INV;
      r_dp        <= ACTIVE_LOW;
      r_an        <= AN_INV;
    end else begin
      if (en) begin
        r_disp <= value;
      end

      if (w_strobe) begin
        r_scan_cnt <= '0;
        r_sel      <= (r_sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_ph  <= ~r_blink_ph;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end

      // A fresh carry reload wins over a same-cycle slot decrement.
      if (en && co) begin
        r_dp_cnt <= DP_LOAD;
      end else if (w_strobe && (r_dp_cnt != '0)) begin
        r_dp_cnt <= r_dp_cnt - DW'(1);
      end

      r_seg <= w_seg ^ SEG_INV;
      r_dp  <= w_dp ^ ACTIVE_LOW;
      r_an  <= w_an ^ AN_INV;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg_scan_60.sv
// Bench for seg_scan_60: directed scenarios plus random traffic, checked each cycle
// against an arithmetic model indexed by the number of clock edges since reset release.
module tb_seg_scan_60;

  localparam int SCAN  = 4;
  localparam int BLNK  = 2;
  localparam int HOLD  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [6:0] value = '0;
  logic       co = 1'b0;
  logic       blink = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;

  int checks = 0;
  int failures = 0;

  // model state
  int  n = 0;
  int  m_disp = 0;
  bit  m_co_valid = 1'b0;
  int  m_co_edge = 0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg_scan_60 #(
    .SCAN_DIV(SCAN),
    .BLINK_SLOTS(BLNK),
    .DP_HOLD_SLOTS(HOLD),
    .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .value(value),
    .co(co),
    .blink(blink),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // One clock edge: check the outputs produced by this edge, then absorb the inputs it captured.
  task automatic step();
    int s, sel, ph, strobes_since;
    bit blank;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] e_an;
    @(posedge clk);
    #1;
    s     = n / SCAN;
    sel   = s % 2;
    ph    = (s / BLNK) % 2;
    blank = blink && (ph == 1);
    e_an  = (sel == 1) ? 2'b10 : 2'b01;
    if (blank) e_seg = 7'h00;
    else if (m_disp >= 60) e_seg = 7'h40;
    else e_seg = seg_tab[(sel == 1) ? (m_disp / 10) : (m_disp % 10)];
    strobes_since = s - (m_co_edge + 1) / SCAN;
    e_dp = !blank && (sel == 0) && m_co_valid && (strobes_since < HOLD);
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("an", {6'b0, an}, {6'b0, e_an});
    chk("dp", {7'b0, dp}, {7'b0, e_dp});
    if (en) m_disp = int'(value);
    if (en && co) begin
      m_co_valid = 1'b1;
      m_co_edge  = n;
    end
    n++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, {1'b0, seg}, 8'h00);
    chk({tag, "_an"}, {6'b0, an}, 8'h00);
    chk({tag, "_dp"}, {7'b0, dp}, 8'h00);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst        = 1'b0;
    n          = 0;
    m_disp     = 0;
    m_co_valid = 1'b0;
    m_co_edge  = 0;
  endtask

  task automatic load(input int v, input bit c);
    en    = 1'b1;
    value = 7'(v);
    co    = c;
    step();
    en    = 1'b0;
    co    = 1'b0;
  endtask

  initial begin
    // 1. reset and power-up scan
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst_hold");
    release_reset();
    run(12);

    // 2. digit split
    load(47, 1'b0);
    run(16);

    // 3. out-of-range then top legal value
    load(60, 1'b0);
    run(9);
    load(59, 1'b0);
    run(9);

    // 4. carry stretch with a retrigger after two strobes
    load(0, 1'b1);
    run(20);
    load(0, 1'b1);
    run(7);
    load(0, 1'b1);
    run(20);
    // co without en must be ignored
    co = 1'b1;
    run(8);
    co = 1'b0;

    // 5. blink
    blink = 1'b1;
    load(23, 1'b1);
    run(24);
    blink = 1'b0;
    run(8);

    // 6. async reset mid-slot
    run(2);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("async_rst_hold");
    release_reset();
    run(10);

    // 7. random traffic
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 3) == 0);
      value = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(60, 127))
                                          : 7'($urandom_range(0, 59));
      co    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blink = ~blink;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_60.md
# seg_scan_60

Two-digit multiplexed seven-segment display driver for the modulo-60 seconds/minutes counter. It sits directly downstream of that counter and consumes its 7-bit binary count and its carry. It splits the count into tens and ones, time-multiplexes the two digits onto one shared segment bus, stretches the carry into a visible decimal-point flash, and supports a blink mode for time-setting.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range 2..2^20.
- BLINK_SLOTS, 250: digit slots per blink half-period; legal range 1..2^16.
- DP_HOLD_SLOTS, 100: digit slots the decimal point stays lit after a carry; legal range 1..2^16.
- ACTIVE_LOW, 1: when 1, seg, dp and an are inverted at the output registers.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  update enable; value is captured on clk edges where en=1.
- value  in  7  binary count from the upstream counter; legal range 0..59.
- co  in  1  carry/terminal-count flag from the upstream counter.
- blink  in  1  1 = blank both digits on alternate blink half-periods.
- seg  out  7  segments {g,f,e,d,c,b,a}; logical 1 = lit before ACTIVE_LOW inversion.
- dp  out  1  decimal point of the ones digit.
- an  out  2  digit enables, one-hot: an[0] = ones, an[1] = tens.

## Operation
- **Capture.** disp_reg (7 bit) loads value on every clk edge with en=1 and holds otherwise.
- **Out-of-range values.** disp_reg values 60..127 are displayed as dash (0x40) on both digits.
- **Digit split.** tens = disp_reg/10 and ones = disp_reg%10, both derived combinationally from disp_reg. Both digits are always shown, with no leading-zero blanking; 5 displays as "05".
- **Segment codes.** 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40. All-off is 00.
- **Scan counter.**
  - scan_cnt counts 0..SCAN_DIV-1 and then wraps to 0.
  - The wrap cycle is the slot strobe.
  - sel toggles on each slot strobe; sel=0 selects the ones digit.
- **Blink.**
  - blink_cnt counts slot strobes over 0..BLINK_SLOTS-1; each wrap toggles blink_ph.
  - When blink=1 and blink_ph=1: seg=00, dp=0 and an still scans.
  - When blink=0: blink_ph is ignored but keeps running.
- **Decimal-point stretch.**
  - co=1 together with en=1 on a clk edge loads dp_cnt with DP_HOLD_SLOTS.
  - Each slot strobe decrements dp_cnt while it is nonzero.
  - dp is lit only while dp_cnt≠0 and sel=0.
  - If a new co arrives while dp_cnt≠0, dp_cnt reloads to DP_HOLD_SLOTS. The reload takes priority over a decrement in the same cycle.
- **Output registers.** seg, dp and an are registered.
  - They are computed from the current sel, disp_reg, blink state and dp_cnt.
  - ACTIVE_LOW inversion is applied at the register input.

## Timing
- **Reset (asynchronous).**
  - Internal state clears to: disp_reg=0, scan_cnt=0, sel=0, blink_cnt=0, blink_ph=0, dp_cnt=0.
  - Output registers show all-off: seg, dp and an logically 0. With ACTIVE_LOW=1 this is seg=7F, dp=1, an=11.
- **After reset release.**
  - First clk edge: outputs show ones digit "0" (an logical 01, seg 3F).
  - Tens digit appears on the edge after the first slot strobe, i.e. SCAN_DIV cycles after release.
- **Latency.**
  - value → disp_reg: 1 cycle.
  - disp_reg → seg: 1 cycle.
  - Total: 2 cycles when the matching digit is already selected.
- **Dwell.** Each digit is enabled for exactly SCAN_DIV cycles; the full refresh period is 2·SCAN_DIV.
- **Digit switch.** an and seg change on the same edge; the bus never carries one digit's segments with the other digit's enable.
- **co without en.** co while en=0 is ignored; co is captured only alongside an update.
- **Reset mid-operation.** Asserting rst mid-slot forces the reset values immediately, without waiting for a clock edge.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_SLOTS=2, DP_HOLD_SLOTS=3, ACTIVE_LOW=0.

1. **Reset.** Assert rst, then release it → seg=00, an=00, dp=0 while rst is high. First edge after release gives an=01, seg=3F. After 4 cycles: an=10, seg=3F.
2. **Digit split.** en=1, value=47 for one cycle → ones slot shows seg=07 and tens slot shows seg=66. Each slot lasts 4 cycles and the pattern alternates.
3. **Out-of-range value.** value=60 with en=1 → both slots show seg=40. A following value=59 → ones slot shows 6F, tens slot shows 6D.
4. **Carry stretch.** co=1 with en=1 and value=0 → dp=1 only during ones slots for 3 slot strobes, then 0. A second co after 2 strobes → dp stays lit for 3 more strobes.
5. **Blink.** blink=1 → seg=00 and dp=0 for 2 slots, then digits visible for 2 slots, repeating. an keeps toggling throughout.
6. **Async reset mid-slot.** Assert rst in the middle of a slot → all outputs go to 0 immediately, before the next clk edge. After release, scanning restarts at the ones digit with seg=3F.
